v810_bus_ctlr: RTL and testbench
================================

// Module: v810_bus_ctlr
//
// PURPOSE
//  Memory-bus sequencer between the v810 core and its slaves (RAM, ROM
//  behind data_bus_resizer). Decodes each bus cycle to a region, drives
//  chip enables, inserts per-region wait states and generates READYn. An
//  access to an unmapped address completes after a timeout with read data 0.
//  That access is logged in a sticky error register.
//
// PARAMETERS
//  RAM_WS    0   wait states for RAM region (A[31]==0), 0..15
//  ROM_WS    2   wait states for ROM region (A[31:20]==12'hFFF), 0..15
//  TIMEOUT   15  CE cycles before an unmapped access is forced complete, 1..255
//
// PORTS
//  CLK       in   1   clock
//  RES       in   1   synchronous reset, active high
//  CE        in   1   clock enable; all state advances only when CE=1
//  A         in   32  CPU address
//  MRQn      in   1   CPU memory request, active low
//  BCYSTn    in   1   CPU bus-cycle start (T1), active low
//  RAM_CEn   out  1   RAM chip enable, active low
//  ROM_CEn   out  1   ROM chip enable, active low
//  READYn    out  1   to CPU; low = current cycle completes at this CE
//  UNMAP     out  1   high while servicing an unmapped cycle; the top level forces D_I=0
//  ERR_VALID out  1   sticky: an unmapped access timed out
//  ERR_A     out  32  address of first timed-out access since last clear
//  ERR_CLR   in   1   clears ERR_VALID/ERR_A (CE-qualified)
//
// BEHAVIOUR
//  - Reset: on a CLK edge with RES=1 the block resets regardless of CE.
//    The state goes to IDLE. READYn=1, RAM_CEn=1, ROM_CEn=1, UNMAP=0,
//    ERR_VALID=0, ERR_A=0.
//  - Decode (combinational): RAM if ~A[31]; ROM if A[31:20]==FFF; else UNMAPPED.
//  - Region register REG is latched at T1: a CE cycle in IDLE (or READY)
//    with BCYSTn=0 and MRQn=0. ADDR is latched with it.
//  - Chip enables are driven as follows:
//      * In the T1 cycle they follow the combinational decode, gated by ~MRQn.
//      * From T1 until READY they come from REG.
//      * In IDLE they are deasserted.
//  - FSM states: IDLE, WAIT, READY.
//      * IDLE -> READY when T1 is seen and the region wait count is 0.
//      * IDLE -> WAIT with CNT=ws-1 when T1 is seen and the wait count is >0.
//      * For UNMAPPED, CNT=TIMEOUT-1 and the FSM always goes to WAIT.
//      * WAIT: CNT decrements each CE cycle. WAIT -> READY when CNT==0.
//      * READY: READYn=0 for exactly one CE cycle.
//      * READY -> WAIT/READY when a new T1 is seen in that same cycle
//        (back-to-back cycle). Otherwise READY -> IDLE.
//  - READYn is registered.
//      * WS=0: low in the first T2 (the CE cycle after T1).
//      * WS=N: low in T2 number N+1.
//  - UNMAP=1 from T1 through READY of an unmapped cycle.
//  - Error log, written on the CE edge that enters READY for an UNMAPPED cycle:
//      * If ERR_VALID=0: ERR_A<=ADDR and ERR_VALID<=1.
//      * If ERR_VALID=1: the log keeps its first error.
//  - ERR_CLR vs. new error in the same CE cycle: the new error wins
//    (ERR_VALID=1, ERR_A=new address).
//  - BCYSTn while in WAIT is ignored; the core never issues it there.
//  - MRQn=1 at T1 means an I/O or idle cycle: no chip enable is driven and
//    the cycle is treated as RAM_WS timing.
//  - CE=0: all registers hold and outputs are stable.
//  - RES mid-WAIT: the cycle is abandoned and the FSM goes to IDLE.
//    ERR_* are cleared.
//
// TESTING
//  1. RAM read, A=0x0000_0100, RAM_WS=0 -> RAM_CEn low T1..T2; READYn low
//     1 CE after T1; ROM_CEn stays 1.
//  2. ROM fetch, A=0xFFFF_FFF0, ROM_WS=2 -> ROM_CEn low 4 CE cycles; READYn
//     low only in the 3rd T2.
//  3. Unmapped access, A=0x8000_0000, TIMEOUT=15 -> READYn low at CE cycle
//     16 after T1; UNMAP=1 throughout; ERR_VALID=1, ERR_A=0x8000_0000.
//  4. Second unmapped access to 0x9000_0004 with no clear -> ERR_A stays
//     0x8000_0000. Then ERR_CLR together with a third error to 0xA000_0000
//     -> ERR_A=0xA000_0000 and ERR_VALID=1.
//  5. Back-to-back cycles: ROM (WS=2) T1 issued in the READY cycle of a
//     RAM cycle -> ROM_CEn asserted the next CE with no IDLE gap; READYn
//     pattern 0,1,1,0.
//  6. RES asserted with CE=0 during WAIT of a ROM access -> next CLK edge
//     gives all outputs at reset values. A RAM T1 then issued sees correct
//     timing.

Source files
------------

// File: rtl/v810_bus_ctlr.sv
// v810 memory-bus sequencer: region decode, chip enables, per-region wait states, READYn, unmapped timeout and error log.
// READYn is registered and drops WS+1 CE cycles after T1; every state change is gated by CE.
module v810_bus_ctlr #(
  parameter int RAM_WS  = 0,
  parameter int ROM_WS  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic        MRQn,
  input  logic        BCYSTn,
  output logic        RAM_CEn,
  output logic        ROM_CEn,
  output logic        READYn,
  output logic        UNMAP,
  output logic        ERR_VALID,
  output logic [31:0] ERR_A,
  input  logic        ERR_CLR
);

  localparam logic [7:0] RAM_W = 8'(RAM_WS);
  localparam logic [7:0] ROM_W = 8'(ROM_WS);
  localparam logic [7:0] TMO_W = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
  typedef enum logic [1:0] {RGN_NONE, RGN_RAM, RGN_ROM, RGN_UNM} rgn_t;

  state_t      state;
  rgn_t        rgn;
  rgn_t        dec;
  rgn_t        cur;
  logic [31:0] addr;
  logic [7:0]  cnt;
  logic [7:0]  dec_wait;
  logic        t1;
  logic        err_evt;

  // MRQn=1 marks an I/O or idle cycle: no chip enable, RAM timing.
  always_comb begin
    dec = RGN_UNM;
    if (MRQn)
      dec = RGN_NONE;
    else if (!A[31])
      dec = RGN_RAM;
    else if (A[31:20] == 12'hFFF)
      dec = RGN_ROM;
  end

  always_comb begin
    case (dec)
      RGN_ROM: dec_wait = ROM_W;
      RGN_UNM: dec_wait = TMO_W;
      default: dec_wait = RAM_W;
    endcase
  end

  assign t1      = CE && !BCYSTn && (state != WAIT);
  assign err_evt = (state == WAIT) && (cnt == 8'd0) && (rgn == RGN_UNM);

  // The T1 cycle shows the live decode; afterwards the latched region holds until READY ends.
  assign cur     = t1 ? dec : ((state == IDLE) ? RGN_NONE : rgn);
  assign RAM_CEn = (cur != RGN_RAM);
  assign ROM_CEn = (cur != RGN_ROM);
  assign UNMAP   = (cur == RGN_UNM);

  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= IDLE;
      rgn       <= RGN_NONE;
      addr      <= 32'd0;
      cnt       <= 8'd0;
      READYn    <= 1'b1;
      ERR_VALID <= 1'b0;
      ERR_A     <= 32'd0;
    end else if (CE) begin
      if (t1) begin
        rgn  <= dec;
        addr <= A;
        if (dec_wait == 8'd0) begin
          state  <= READY;
          READYn <= 1'b0;
        end else begin
          state  <= WAIT;
          cnt    <= dec_wait - 8'd1;
          READYn <= 1'b1;
        end
      end else begin
        case (state)
          WAIT: begin
            if (cnt == 8'd0) begin
              state  <= READY;
              READYn <= 1'b0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          READY: begin
            state  <= IDLE;
            READYn <= 1'b1;
          end
          default: READYn <= 1'b1;
        endcase
      end

      // A new timeout beats a simultaneous clear; otherwise the first error sticks.
      if (err_evt && (!ERR_VALID || ERR_CLR)) begin
        ERR_VALID <= 1'b1;
        ERR_A     <= addr;
      end else if (ERR_CLR) begin
        ERR_VALID <= 1'b0;
        ERR_A     <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_v810_bus_ctlr.sv
// Bench for v810_bus_ctlr: decode table, error-log/back-to-back/reset sequences, randomized run against a schedule model.
module tb_v810_bus_ctlr;
  localparam int RAM_WS  = 0;
  localparam int ROM_WS  = 2;
  localparam int TIMEOUT = 15;
  localparam int NMAX    = 1600;

  logic        CLK = 1'b0;
  logic        RES, CE, MRQn, BCYSTn, ERR_CLR;
  logic [31:0] A;
  logic        RAM_CEn, ROM_CEn, READYn, UNMAP, ERR_VALID;
  logic [31:0] ERR_A;

  v810_bus_ctlr #(.RAM_WS(RAM_WS), .ROM_WS(ROM_WS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .MRQn(MRQn), .BCYSTn(BCYSTn),
    .RAM_CEn(RAM_CEn), .ROM_CEn(ROM_CEn), .READYn(READYn), .UNMAP(UNMAP),
    .ERR_VALID(ERR_VALID), .ERR_A(ERR_A), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic        mrqn;
    logic        ram_cen;
    logic        rom_cen;
    logic        unmap;
    int          lat;
  } vec_t;
  vec_t vecs [8];

  logic t1_ram, t1_rom, t1_unm, t1_rdy, held;
  int   lat;

  logic rdy_exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic rom_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic ram_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  // Expected per-CE-cycle outputs built from whole transactions.
  bit          exp_ram  [NMAX];
  bit          exp_rom  [NMAX];
  bit          exp_rdy  [NMAX];
  bit          exp_unm  [NMAX];
  bit          unm_done [NMAX];
  logic [31:0] unm_addr [NMAX];
  int          n, next_ok, r, ws;
  logic        iss, mq, clr, mv;
  logic [31:0] ra, ma;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    RES = 1'b1; CE = 1'b0; BCYSTn = 1'b1; MRQn = 1'b1; ERR_CLR = 1'b0; A = 32'd0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RES = 1'b0; CE = 1'b1;
  endtask

  // Issues one T1 from IDLE and runs until READYn is seen low (bounded).
  task automatic run_txn(input logic [31:0] a, input logic mrqn, input int clr_at, output int l);
    CE = 1'b1; BCYSTn = 1'b0; MRQn = mrqn; A = a; ERR_CLR = (clr_at == 0);
    @(negedge CLK);
    t1_ram = RAM_CEn; t1_rom = ROM_CEn; t1_unm = UNMAP; t1_rdy = READYn;
    @(posedge CLK); #1;
    BCYSTn = 1'b1; A = 32'h5A5A_0000; MRQn = 1'b1;
    held = 1'b1;
    l = -1;
    for (int i = 1; i <= 40 && l < 0; i++) begin
      ERR_CLR = (i == clr_at);
      @(negedge CLK);
      if (RAM_CEn !== t1_ram || ROM_CEn !== t1_rom || UNMAP !== t1_unm) held = 1'b0;
      if (READYn === 1'b0) l = i;
      @(posedge CLK); #1;
    end
    ERR_CLR = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0, RAM_WS + 1};
    vecs[1] = '{32'h7FFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, RAM_WS + 1};
    vecs[2] = '{32'hFFF0_0000, 1'b0, 1'b1, 1'b0, 1'b0, ROM_WS + 1};
    vecs[3] = '{32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 1'b0, ROM_WS + 1};
    vecs[4] = '{32'hFFEF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1, TIMEOUT + 1};
    vecs[5] = '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, TIMEOUT + 1};
    vecs[6] = '{32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b0, RAM_WS + 1};
    vecs[7] = '{32'hFFF0_0000, 1'b1, 1'b1, 1'b1, 1'b0, RAM_WS + 1};

    // Reset state
    do_reset();
    BCYSTn = 1'b1;
    @(negedge CLK);
    chk1("rst_ram_cen", RAM_CEn, 1'b1);
    chk1("rst_rom_cen", ROM_CEn, 1'b1);
    chk1("rst_readyn", READYn, 1'b1);
    chk1("rst_unmap", UNMAP, 1'b0);
    chk1("rst_err_valid", ERR_VALID, 1'b0);
    chk32("rst_err_a", ERR_A, 32'd0);
    @(posedge CLK); #1;

    // Decode and latency table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      run_txn(vecs[v].a, vecs[v].mrqn, -1, lat);
      chk1("tbl_t1_ram", t1_ram, vecs[v].ram_cen);
      chk1("tbl_t1_rom", t1_rom, vecs[v].rom_cen);
      chk1("tbl_t1_unmap", t1_unm, vecs[v].unmap);
      chk1("tbl_t1_readyn", t1_rdy, 1'b1);
      chk32("tbl_latency", lat, vecs[v].lat);
      chk1("tbl_held", held, 1'b1);
      @(negedge CLK);
      chk1("tbl_idle_ram", RAM_CEn, 1'b1);
      chk1("tbl_idle_rom", ROM_CEn, 1'b1);
      chk1("tbl_idle_unmap", UNMAP, 1'b0);
      chk1("tbl_idle_readyn", READYn, 1'b1);
      chk1("tbl_err_valid", ERR_VALID, vecs[v].unmap);
      @(posedge CLK); #1;
    end

    // Error log: first error sticks, clear plus new error keeps the new one
    do_reset();
    run_txn(32'h8000_0000, 1'b0, -1, lat);
    chk32("err1_latency", lat, TIMEOUT + 1);
    chk1("err1_valid", ERR_VALID, 1'b1);
    chk32("err1_addr", ERR_A, 32'h8000_0000);
    run_txn(32'h9000_0004, 1'b0, -1, lat);
    chk32("err2_addr", ERR_A, 32'h8000_0000);
    run_txn(32'hA000_0000, 1'b0, TIMEOUT, lat);
    chk1("err3_valid", ERR_VALID, 1'b1);
    chk32("err3_addr", ERR_A, 32'hA000_0000);
    ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    chk1("clr_valid", ERR_VALID, 1'b0);
    chk32("clr_addr", ERR_A, 32'd0);

    // Back-to-back: ROM T1 in the READY cycle of a RAM cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      BCYSTn = !(i == 0 || i == 1);
      MRQn = 1'b0;
      A = (i == 0) ? 32'h0000_0100 : 32'hFFFF_FFF0;
      @(negedge CLK);
      chk1("b2b_readyn", READYn, rdy_exp[i]);
      chk1("b2b_rom_cen", ROM_CEn, rom_exp[i]);
      chk1("b2b_ram_cen", RAM_CEn, ram_exp[i]);
      @(posedge CLK); #1;
    end
    BCYSTn = 1'b1;

    // Reset with CE=0 during a ROM wait
    do_reset();
    run_txn(32'h8000_0000, 1'b0, -1, lat);
    chk1("rw_err_pre", ERR_VALID, 1'b1);
    BCYSTn = 1'b0; MRQn = 1'b0; A = 32'hFFFF_FFF0;
    @(negedge CLK);
    chk1("rw_t1_rom", ROM_CEn, 1'b0);
    @(posedge CLK); #1;
    BCYSTn = 1'b1;
    @(negedge CLK);
    chk1("rw_wait_rom", ROM_CEn, 1'b0);
    CE = 1'b0; RES = 1'b1;
    @(posedge CLK); #1;
    RES = 1'b0; CE = 1'b1;
    @(negedge CLK);
    chk1("rw_ram_cen", RAM_CEn, 1'b1);
    chk1("rw_rom_cen", ROM_CEn, 1'b1);
    chk1("rw_readyn", READYn, 1'b1);
    chk1("rw_unmap", UNMAP, 1'b0);
    chk1("rw_err_valid", ERR_VALID, 1'b0);
    chk32("rw_err_a", ERR_A, 32'd0);
    @(posedge CLK); #1;
    run_txn(32'h0000_0200, 1'b0, -1, lat);
    chk1("rw_ram_t1", t1_ram, 1'b0);
    chk32("rw_ram_latency", lat, RAM_WS + 1);

    // Randomized run against the transaction schedule model
    for (int i = 0; i < NMAX; i++) begin
      exp_ram[i] = 1'b1; exp_rom[i] = 1'b1; exp_rdy[i] = 1'b1;
      exp_unm[i] = 1'b0; unm_done[i] = 1'b0; unm_addr[i] = 32'd0;
    end
    do_reset();
    n = 0; next_ok = 0; mv = 1'b0; ma = 32'd0;
    for (int cyc = 0; cyc < 5000 && n < 1450; cyc++) begin
      if ($urandom_range(0, 3) != 0) begin
        iss = (n >= next_ok) && (n < 1400) && ($urandom_range(0, 2) == 0);
        r = $urandom_range(0, 3);
        ra = $urandom;
        mq = 1'b0;
        case (r)
          0: ra[31] = 1'b0;
          1: ra[31:20] = 12'hFFF;
          2: begin ra[31] = 1'b1; if (ra[30:20] == 11'h7FF) ra[20] = 1'b0; end
          default: mq = 1'b1;
        endcase
        if (!iss) mq = 1'($urandom_range(0, 1));
        ws = (r == 1) ? ROM_WS : (r == 2) ? TIMEOUT : RAM_WS;
        if (iss) begin
          for (int k = n; k <= n + ws + 1; k++) begin
            exp_ram[k] = (r != 0);
            exp_rom[k] = (r != 1);
            exp_unm[k] = (r == 2);
          end
          exp_rdy[n + ws + 1] = 1'b0;
          if (r == 2) begin
            unm_done[n + ws + 1] = 1'b1;
            unm_addr[n + ws + 1] = ra;
          end
          next_ok = n + ws + 1;
        end
        clr = ($urandom_range(0, 7) == 0);
        CE = 1'b1; BCYSTn = !iss; MRQn = mq; A = ra; ERR_CLR = clr;
        @(negedge CLK);
        chk1("rnd_ram_cen", RAM_CEn, exp_ram[n]);
        chk1("rnd_rom_cen", ROM_CEn, exp_rom[n]);
        chk1("rnd_readyn", READYn, exp_rdy[n]);
        chk1("rnd_unmap", UNMAP, exp_unm[n]);
        chk1("rnd_err_valid", ERR_VALID, mv);
        chk32("rnd_err_a", ERR_A, ma);
        @(posedge CLK); #1;
        if (unm_done[n + 1] && (!mv || clr)) begin
          mv = 1'b1; ma = unm_addr[n + 1];
        end else if (clr) begin
          mv = 1'b0; ma = 32'd0;
        end
        n++;
      end else begin
        CE = 1'b0;
        BCYSTn = 1'($urandom_range(0, 1));
        MRQn = 1'($urandom_range(0, 1));
        A = $urandom;
        ERR_CLR = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk1("hold_readyn", READYn, exp_rdy[n]);
        chk1("hold_err_valid", ERR_VALID, mv);
        chk32("hold_err_a", ERR_A, ma);
        @(posedge CLK); #1;
      end
    end
    CE = 1'b1; BCYSTn = 1'b1; ERR_CLR = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
